// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/PPU arbiter sharing one external memory port
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int STARVE = 3
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_a_i,
  input  logic [DW-1:0] cpu_d_i,
  output logic [DW-1:0] cpu_q_o,
  output logic          cpu_ack_o,
  input  logic          ppu_req_i,
  input  logic          ppu_we_i,
  input  logic [AW-1:0] ppu_a_i,
  input  logic [DW-1:0] ppu_d_i,
  output logic [DW-1:0] ppu_q_o,
  output logic          ppu_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_a_o,
  output logic [DW-1:0] mem_d_o,
  input  logic [DW-1:0] mem_q_i,
  input  logic          mem_ack_i,
  output logic          busy_o
);

  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    PPU_XFER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_d_q, mem_d_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ppu_ack_q, ppu_ack_d;
  logic [DW-1:0] cpu_q_q, cpu_q_d;
  logic [DW-1:0] ppu_q_q, ppu_q_d;

  logic is_idle, eff_cpu, eff_ppu, starved, grant_cpu, grant_ppu;

  // A port whose ack is high this cycle is masked so it cannot be re-granted
  // on the stale request it is about to drop.
  assign is_idle   = (state_q == IDLE);
  assign eff_cpu   = cpu_req_i & ~cpu_ack_q;
  assign eff_ppu   = ppu_req_i & ~ppu_ack_q;
  assign starved   = (starve_q == SW'(STARVE));
  assign grant_cpu = is_idle & eff_cpu & (starved | ~eff_ppu);
  assign grant_ppu = is_idle & eff_ppu & ~(eff_cpu & starved);

  // State register; reset drops the memory request immediately
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state: grant from IDLE, return to IDLE on memory completion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_cpu)      state_d = CPU_XFER;
        else if (grant_ppu) state_d = PPU_XFER;
      end
      CPU_XFER, PPU_XFER: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch the winner, capture read data, count starvation
  always_comb begin
    mem_we_d  = mem_we_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    cpu_ack_d = 1'b0;
    ppu_ack_d = 1'b0;
    cpu_q_d   = cpu_q_q;
    ppu_q_d   = ppu_q_q;
    starve_d  = starve_q;

    if (grant_cpu) begin
      mem_we_d = cpu_we_i;
      mem_a_d  = cpu_a_i;
      mem_d_d  = cpu_d_i;
    end else if (grant_ppu) begin
      mem_we_d = ppu_we_i;
      mem_a_d  = ppu_a_i;
      mem_d_d  = ppu_d_i;
    end

    if (is_idle) begin
      if (grant_cpu || !cpu_req_i)  starve_d = '0;
      else if (grant_ppu && !starved) starve_d = starve_q + SW'(1);
    end

    if (state_q == CPU_XFER && mem_ack_i) begin
      cpu_ack_d = 1'b1;
      if (!mem_we_q) cpu_q_d = mem_q_i;
    end
    if (state_q == PPU_XFER && mem_ack_i) begin
      ppu_ack_d = 1'b1;
      if (!mem_we_q) ppu_q_d = mem_q_i;
    end
  end

  // Registered outputs and starvation counter
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_we_q  <= 1'b0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      cpu_ack_q <= 1'b0;
      ppu_ack_q <= 1'b0;
      cpu_q_q   <= '0;
      ppu_q_q   <= '0;
      starve_q  <= '0;
    end else begin
      mem_we_q  <= mem_we_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
      cpu_ack_q <= cpu_ack_d;
      ppu_ack_q <= ppu_ack_d;
      cpu_q_q   <= cpu_q_d;
      ppu_q_q   <= ppu_q_d;
      starve_q  <= starve_d;
    end
  end

  assign mem_req_o = ~is_idle;
  assign busy_o    = ~is_idle;
  assign mem_we_o  = mem_we_q;
  assign mem_a_o   = mem_a_q;
  assign mem_d_o   = mem_d_q;
  assign cpu_ack_o = cpu_ack_q;
  assign ppu_ack_o = ppu_ack_q;
  assign cpu_q_o   = cpu_q_q;
  assign ppu_q_o   = ppu_q_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int STARVE = 3;
  localparam int VW     = 3 + AW + DW + 2 * (1 + DW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_v = '0;
  logic [1:0]    we_v = '0;
  logic [AW-1:0] a_v [2];
  logic [DW-1:0] d_v [2];
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_q = '0;

  logic [DW-1:0] cpu_q_o, ppu_q_o, mem_d_o;
  logic          cpu_ack_o, ppu_ack_o, mem_req_o, mem_we_o, busy_o;
  logic [AW-1:0] mem_a_o;
  logic [1:0]    ack_v;

  assign ack_v = {ppu_ack_o, cpu_ack_o};

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .cpu_req_i (req_v[0]),
    .cpu_we_i  (we_v[0]),
    .cpu_a_i   (a_v[0]),
    .cpu_d_i   (d_v[0]),
    .cpu_q_o   (cpu_q_o),
    .cpu_ack_o (cpu_ack_o),
    .ppu_req_i (req_v[1]),
    .ppu_we_i  (we_v[1]),
    .ppu_a_i   (a_v[1]),
    .ppu_d_i   (d_v[1]),
    .ppu_q_o   (ppu_q_o),
    .ppu_ack_o (ppu_ack_o),
    .mem_req_o (mem_req_o),
    .mem_we_o  (mem_we_o),
    .mem_a_o   (mem_a_o),
    .mem_d_o   (mem_d_o),
    .mem_q_i   (mem_q),
    .mem_ack_i (mem_ack),
    .busy_o    (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int            mem_lat  = 3;
  bit            rand_lat = 1'b0;
  bit            rand_q   = 1'b0;
  bit            unsol_en = 1'b0;
  logic [DW-1:0] mem_qval = '0;
  int            wait_n   = 0;

  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      wait_n  = 0;
      if (rand_lat) mem_lat = int'($urandom_range(1, 4));
    end else if (mem_req_o) begin
      wait_n++;
      if (wait_n >= mem_lat) begin
        mem_ack = 1'b1;
        mem_q   = rand_q ? DW'($urandom) : mem_qval;
      end
    end else begin
      wait_n = 0;
      mem_q  = DW'($urandom);
      if (unsol_en && $urandom_range(0, 1) == 0) mem_ack = 1'b1;
    end
  end

  // ---------------- behavioural reference model ----------------
  // Port index 0 = CPU, 1 = PPU; owner -1 means the memory port is free.
  int            m_owner;
  int            m_streak;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [1:0]    m_ack;
  logic [DW-1:0] m_q [2];

  task automatic model_reset();
    m_owner  = -1;
    m_streak = 0;
    m_we     = 1'b0;
    m_a      = '0;
    m_d      = '0;
    m_ack    = '0;
    m_q[0]   = '0;
    m_q[1]   = '0;
  endtask

  task automatic model_step();
    int win;
    logic [1:0] want;
    want  = req_v & ~m_ack;
    m_ack = '0;
    if (m_owner < 0) begin
      win = -1;
      if (want[0] && m_streak == STARVE) win = 0;
      else if (want[1])                  win = 1;
      else if (want[0])                  win = 0;
      if (!req_v[0] || win == 0)          m_streak = 0;
      else if (win == 1 && m_streak < STARVE) m_streak++;
      if (win >= 0) begin
        m_owner = win;
        m_we    = we_v[win];
        m_a     = a_v[win];
        m_d     = d_v[win];
      end
    end else if (mem_ack) begin
      m_ack[m_owner] = 1'b1;
      if (!m_we) m_q[m_owner] = mem_q;
      m_owner = -1;
    end
  endtask

  initial model_reset();

  // Compare every cycle on the falling edge, then advance the model to the next rising edge
  logic [VW-1:0] act_v, exp_v;
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    act_v = {busy_o, mem_req_o, mem_we_o, mem_a_o, mem_d_o, cpu_ack_o, cpu_q_o, ppu_ack_o, ppu_q_o};
    exp_v = {m_owner >= 0, m_owner >= 0, m_we, m_a, m_d, m_ack[0], m_q[0], m_ack[1], m_q[1]};
    check("cycle{busy,req,we,a,d,cack,cq,pack,pq}", 64'(act_v), 64'(exp_v));
    if (rst_n) model_step();
  end

  // ---------------- stimulus helpers ----------------
  bit [1:0] done = '0;
  bit [1:0] hold = '0;

  task automatic raise(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v[p] = 1'b1;
    we_v[p]  = we;
    a_v[p]   = a;
    d_v[p]   = d;
  endtask

  task automatic new_req(input int p);
    raise(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic drive_port(input int p);
    if (done[p]) begin
      done[p] = 1'b0;
      if (hold[p]) new_req(p);
      else         req_v[p] = 1'b0;
    end else if (req_v[p] && ack_v[p]) begin
      done[p] = 1'b1;
    end else if (!req_v[p] && $urandom_range(0, 3) == 0) begin
      new_req(p);
    end
  endtask

  task automatic wait_ack(input int p, output int cyc);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      cyc++;
      if (ack_v[p]) return;
    end
    check($sformatf("timeout_ack%0d", p), 64'(0), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  int cyc;
  int seen;

  initial begin
    a_v[0] = '0; a_v[1] = '0; d_v[0] = '0; d_v[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy",    64'(busy_o),    64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_a",   64'(mem_a_o),   64'(0));
    check("rst_qs",      64'({cpu_q_o, ppu_q_o}), 64'(0));
    check("rst_acks",    64'(ack_v),     64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk);

    // CPU read 8000, memory answers A9 after 3 cycles
    #1; raise(0, 1'b0, 16'h8000, 8'h00); mem_lat = 3; mem_qval = 8'hA9;
    @(posedge clk); #2;
    check("t1_mem_req", 64'(mem_req_o), 64'(1));
    check("t1_mem_a",   64'(mem_a_o),   64'(16'h8000));
    check("t1_mem_we",  64'(mem_we_o),  64'(0));
    wait_ack(0, cyc);
    check("t1_latency", 64'(cyc),     64'(3));
    check("t1_cpu_q",   64'(cpu_q_o), 64'(8'hA9));
    check("t1_model_q", 64'(m_q[0]),  64'(8'hA9));
    check("t1_req_drop", 64'(mem_req_o), 64'(0));
    @(posedge clk); #1; req_v[0] = 1'b0; #1;
    check("t1_ack_pulse", 64'(cpu_ack_o), 64'(0));

    // CPU write 0300 <- 5C; read data must not be captured
    @(posedge clk); #1; raise(0, 1'b1, 16'h0300, 8'h5C); mem_qval = 8'h11;
    @(posedge clk); #2;
    check("t4_mem_we", 64'(mem_we_o), 64'(1));
    check("t4_mem_d",  64'(mem_d_o),  64'(8'h5C));
    check("t4_mem_a",  64'(mem_a_o),  64'(16'h0300));
    wait_ack(0, cyc);
    check("t4_cpu_q_kept", 64'(cpu_q_o), 64'(8'hA9));
    @(posedge clk); #1; req_v[0] = 1'b0;

    // Simultaneous requests: PPU first, CPU on the edge right after ppu_ack
    @(posedge clk); #1;
    raise(0, 1'b0, 16'h1111, 8'h00);
    raise(1, 1'b0, 16'h2222, 8'h00);
    mem_lat = 2; mem_qval = 8'h3C;
    @(posedge clk); #2;
    check("t2_first_ppu", 64'(mem_a_o), 64'(16'h2222));
    wait_ack(1, cyc);
    check("t2_ppu_q",    64'(ppu_q_o),   64'(8'h3C));
    check("t2_cpu_wait", 64'(cpu_ack_o), 64'(0));
    @(posedge clk); #1; req_v[1] = 1'b0; #1;
    check("t2_cpu_req_next", 64'(mem_req_o), 64'(1));
    check("t2_cpu_a_next",   64'(mem_a_o),   64'(16'h1111));
    wait_ack(0, cyc);
    check("t2_cpu_q", 64'(cpu_q_o), 64'(8'h3C));
    @(posedge clk); #1; req_v[0] = 1'b0;

    // Unsolicited mem_ack while idle
    @(posedge clk); #1; unsol_en = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (cpu_ack_o || ppu_ack_o || busy_o) seen++;
    end
    unsol_en = 1'b0;
    check("t6_no_ack",  64'(seen),    64'(0));
    check("t6_cpu_q",   64'(cpu_q_o), 64'(8'h3C));
    check("t6_ppu_q",   64'(ppu_q_o), 64'(8'h3C));
    repeat (2) @(posedge clk);

    // Reset during a PPU transfer, then re-arbitration of held requests
    #1; raise(1, 1'b0, 16'h4444, 8'h00); mem_lat = 6; mem_qval = 8'h77;
    @(posedge clk); #2;
    check("t5_busy_before", 64'(busy_o), 64'(1));
    #1; rst_n = 1'b0; #1;
    check("t5_mem_req", 64'(mem_req_o), 64'(0));
    check("t5_busy",    64'(busy_o),    64'(0));
    check("t5_outs",    64'({mem_we_o, mem_a_o, mem_d_o, cpu_q_o, ppu_q_o, ack_v}), 64'(0));
    raise(0, 1'b0, 16'h5555, 8'h00);
    @(posedge clk); #1; rst_n = 1'b1; mem_lat = 2;
    @(posedge clk); #2;
    check("t5_rearb_ppu", 64'(mem_a_o), 64'(16'h4444));
    wait_ack(1, cyc);
    check("t5_ppu_q", 64'(ppu_q_o), 64'(8'h77));
    @(posedge clk); #1; req_v[1] = 1'b0;
    wait_ack(0, cyc);
    check("t5_cpu_q", 64'(cpu_q_o), 64'(8'h77));
    @(posedge clk); #1; req_v[0] = 1'b0;

    // Randomized traffic checked against the model every cycle
    rand_q = 1'b1; rand_lat = 1'b1; unsol_en = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      hold[0] = 1'($urandom_range(0, 1));
      hold[1] = 1'($urandom_range(0, 1));
      for (int c = 0; c < 500; c++) begin
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) drive_port(p);
      end
    end

    @(posedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
